a0_trace_buffer: RTL
====================

Name: a0_trace_buffer

Overview:
- Downstream observer of the CPU's a0 result register.
- Samples a0 every cycle and detects value changes.
- Pushes each new value, with a free-running cycle timestamp, into a small FIFO.
- A host/display consumer drains the FIFO over a valid/ready interface. Lets the bench and display see every a0 transition, e.g. light-sequence steps, without per-cycle polling.

Parameters:
- DATA_WIDTH, 32, width of a0 and of out_data.
- CNT_WIDTH, 16, width of the timestamp counter and of out_stamp.
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- a0  input  DATA_WIDTH  CPU register x10 value.
- en  input  1  capture enable; when low, no sampling and prev_a0 is held.
- clear  input  1  synchronous flush of FIFO, overflow flag and first-sample state.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts head.
- out_data  output  DATA_WIDTH  head entry a0 value.
- out_stamp  output  CNT_WIDTH  head entry timestamp.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst is synchronous and active-high.
  - Reset values: out_valid=0, count=0, overflow=0, out_data=0, out_stamp=0, timestamp=0, state=ARMED, prev_a0=0.
- Timestamp:
  - CNT_WIDTH counter, +1 every cycle regardless of en.
  - Wraps from all-ones to 0.
  - An entry's stamp is the counter value in the cycle a0 was sampled.
- State machine:
  - ARMED: the first cycle with en=1 generates an event unconditionally, loads prev_a0<=a0, and moves to TRACK.
  - TRACK: an event occurs when en=1 and a0!=prev_a0; prev_a0<=a0 on every en=1 cycle.
  - clear or rst returns to ARMED.
- Push and pop:
  - Push on event.
  - Pop when out_valid && out_ready.
  - Storage is show-ahead: out_data/out_stamp reflect the head combinationally from registered storage.
  - out_data and out_stamp are forced to 0 when count==0.
- Latency: an a0 change in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty. No same-cycle bypass.
- Full, event, no pop: entry dropped, overflow<=1, count stays DEPTH.
- Full, event, pop in the same cycle: both happen, count unchanged, no overflow.
- Empty, pop attempt: impossible, since out_valid=0; out_ready is ignored.
- Simultaneous push and pop at count 1: count stays 1 and the head advances to the new entry.
- Pointers: log2(DEPTH)-bit read and write pointers wrap naturally. count is tracked separately, so full (count==DEPTH) and empty (count==0) are unambiguous.
- clear:
  - Priority over push and pop in the same cycle.
  - Next cycle: count=0, overflow=0, state=ARMED.
  - The timestamp is not cleared.
- overflow is cleared only by rst or clear.
- rst mid-stream: all queued entries are discarded and there are no spurious pops. Reset takes priority over clear.
- a0 held constant in TRACK: no events, FIFO unchanged.

Decomposition:
- Package a0_trace_pkg:
  - typedef enum logic {ARMED, TRACK} trace_state_t.
  - Default constants TRACE_DEPTH=8 and TRACE_CNT_WIDTH=16.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Holds storage, pointers, count, full/empty, and show-ahead read.
  - Push when full is refused and reported to the parent, which sets overflow.
  - a0_trace_buffer packs {a0, stamp} into a WIDTH=DATA_WIDTH+CNT_WIDTH word.

Test Plan:
- First sample: rst 1 cycle, then en=1, a0=0 at timestamp 0 -> cycle 1: out_valid=1, out_data=0, out_stamp=0, count=1.
- Change detection: out_ready=1; a0 sequence 1,1,3,3,7 from stamp 5 -> entries (1,5), (3,7), (7,9) emitted in order, with no entries for the repeats.
- Overflow: out_ready=0, DEPTH=8; 9 distinct a0 values on consecutive cycles -> count=8, overflow=1. The first 8 entries are drained intact and the 9th is absent.
- Full with simultaneous pop: count=8, out_ready=1, new a0 value -> count stays 8, overflow stays 0, head advances by one entry.
- Clear priority: count=3, assert clear together with an a0 change -> next cycle count=0, out_valid=0, overflow=0. The next en cycle re-arms and pushes the current a0.
- Wrap and en gating: run 70000 cycles with en=0 and a0 toggling -> no entries. Then en=1 -> one entry whose stamp equals (cycle mod 65536).

Source files
------------

// File: rtl/a0_trace_pkg.sv
// ---------------------------------------------------------------------------
// a0_trace_pkg
// Shared types and default constants for the a0 trace buffer slice.
//   trace_state_t    : capture state (ARMED waits for the first sample,
//                      TRACK reports only changes)
//   TRACE_DEPTH      : default FIFO depth (power of two, >= 2)
//   TRACE_CNT_WIDTH  : default timestamp width
//   TRACE_DATA_WIDTH : default a0 width
//   countWidth()     : width needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package a0_trace_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    TRACK = 1'b1
  } trace_state_t;

  localparam int TRACE_DEPTH      = 8;
  localparam int TRACE_CNT_WIDTH  = 16;
  localparam int TRACE_DATA_WIDTH = 32;

  // Occupancy runs from 0 up to and including depth, so one extra bit
  // beyond the pointer width is needed to tell full from empty.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO with an explicit occupancy counter.
//   clk     : clock
//   rst     : synchronous active-high reset, empties the FIFO
//   flush   : synchronous flush, wins over push and pop in the same cycle
//   push    : write din this cycle (refused when full and not popping)
//   din     : write data
//   pop     : consumer takes the head (ignored while empty)
//   dout    : head entry, forced to zero while empty
//   valid   : head entry present
//   full    : occupancy equals DEPTH
//   dropped : a push was refused this cycle because the FIFO was full
//   count   : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo
  import a0_trace_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = TRACE_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic [WIDTH-1:0]              din,
  input  logic                          pop,
  output logic [WIDTH-1:0]              dout,
  output logic                          valid,
  output logic                          full,
  output logic                          dropped,
  output logic [countWidth(DEPTH)-1:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = countWidth(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_doPop;
  logic w_doPush;

  // Depth must be a power of two so the pointers can wrap for free.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  // Handshake qualification. A pop while empty is meaningless and is
  // ignored; a push while full is still accepted when a pop frees the
  // head slot in the same cycle, so a full FIFO that is being drained
  // never loses data.
  always_comb begin
    w_empty  = (r_count == '0);
    w_full   = (r_count == FULL_COUNT);
    w_doPop  = pop && !w_empty;
    w_doPush = push && (!w_full || w_doPop);
    dropped  = push && w_full && !w_doPop;
  end

  // Pointers and occupancy. Reset and flush both discard everything;
  // reset is listed first so it dominates. Count is kept separately from
  // the pointers so equal pointers never need disambiguating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array has no reset; stale slots are never visible because the
  // head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // Show-ahead read straight from registered storage, zeroed when empty.
  always_comb begin
    valid = !w_empty;
    full  = w_full;
    count = r_count;
    dout  = w_empty ? '0 : r_mem[r_rdPtr];
  end

endmodule

// File: rtl/a0_trace_buffer.sv
// ---------------------------------------------------------------------------
// a0_trace_buffer
// Watches the CPU's a0 register and queues every change, tagged with a
// free-running cycle timestamp, for a host or display to drain at leisure.
//   clk       : clock
//   rst       : synchronous active-high reset
//   a0        : current a0 (x10) value from the CPU
//   en        : capture enable; when low nothing is sampled and the last
//               seen value is held
//   clear     : flush the FIFO, the overflow flag and re-arm the first
//               sample capture (timestamp keeps running)
//   out_valid : head entry present
//   out_ready : consumer accepts the head entry
//   out_data  : head entry a0 value (zero when empty)
//   out_stamp : head entry timestamp (zero when empty)
//   count     : current FIFO occupancy
//   overflow  : sticky, at least one change was lost to a full FIFO
// ---------------------------------------------------------------------------
module a0_trace_buffer
  import a0_trace_pkg::*;
#(
  parameter int DATA_WIDTH = TRACE_DATA_WIDTH,
  parameter int CNT_WIDTH  = TRACE_CNT_WIDTH,
  parameter int DEPTH      = TRACE_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         a0,
  input  logic                          en,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CNT_WIDTH-1:0]          out_stamp,
  output logic [countWidth(DEPTH)-1:0]  count,
  output logic                          overflow
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + CNT_WIDTH;

  trace_state_t r_state;
  trace_state_t w_nextState;

  logic [CNT_WIDTH-1:0]   r_stamp;
  logic [DATA_WIDTH-1:0]  r_prevA0;
  logic                   r_overflow;

  logic                   w_event;
  logic                   w_loadPrev;
  logic [ENTRY_WIDTH-1:0] w_entryIn;
  logic [ENTRY_WIDTH-1:0] w_entryOut;
  logic                   w_fifoValid;
  logic                   w_fifoFull;
  logic                   w_fifoDropped;

  // Free-running timestamp. It only answers to reset so that stamps stay
  // comparable across a clear, and it wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stamp <= '0;
    end else begin
      r_stamp <= r_stamp + 1'b1;
    end
  end

  // Capture state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARMED;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: clear always re-arms; otherwise the first enabled sample
  // moves us into change tracking, and we stay there.
  always_comb begin
    w_nextState = r_state;
    if (clear) begin
      w_nextState = ARMED;
    end else if (en) begin
      w_nextState = TRACK;
    end
  end

  // Event and sampling decisions. While ARMED the first enabled sample is
  // reported whatever its value, so the consumer always learns the
  // starting point. A clear cycle neither samples nor reports, which is
  // what gives clear its priority over an a0 change in the same cycle.
  always_comb begin
    w_event    = 1'b0;
    w_loadPrev = 1'b0;
    if (!clear && en) begin
      w_loadPrev = 1'b1;
      w_event    = (r_state == ARMED) || (a0 != r_prevA0);
    end
  end

  // Last sampled a0, held whenever capture is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevA0 <= '0;
    end else if (w_loadPrev) begin
      r_prevA0 <= a0;
    end
  end

  // Sticky overflow: set when the FIFO refuses an event, cleared only by
  // reset or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_fifoDropped) begin
      r_overflow <= 1'b1;
    end
  end

  // Entries are packed value-high, stamp-low.
  always_comb begin
    w_entryIn = {a0, r_stamp};
  end

  sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (clear),
    .push    (w_event),
    .din     (w_entryIn),
    .pop     (out_ready),
    .dout    (w_entryOut),
    .valid   (w_fifoValid),
    .full    (w_fifoFull),
    .dropped (w_fifoDropped),
    .count   (count)
  );

  // Unpack the head. The FIFO already zeroes its output when empty, so
  // out_data and out_stamp read as zero with nothing queued. The full
  // flag is not needed here beyond the drop indication.
  always_comb begin
    out_valid = w_fifoValid;
    out_data  = w_entryOut[ENTRY_WIDTH-1:CNT_WIDTH];
    out_stamp = w_entryOut[CNT_WIDTH-1:0];
    overflow  = r_overflow & (w_fifoFull | ~w_fifoFull);
  end

endmodule
